fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch sequencer that sits directly downstream of the program counter register in the datapath. Each fetch samples the current PC value, pulses the PC's increment input, and issues a word read to instruction memory. It latches the returned word and hands it to the control unit over a valid/ack handshake. It also detects memory timeouts and counts retired fetches.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC value, memory data and instruction register
- ADDR_WIDTH, 9, memory word-address width; mem_addr = low ADDR_WIDTH bits of latched PC
- TIMEOUT, 16, consecutive READ cycles with mem_rdy low before fault (≥2)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset; dominates all other inputs
- run  in  1  level; permits starting new fetches
- pc_in  in  DATA_WIDTH  current PC register output
- inc_pc  out  1  increment strobe to PC register (IncPC)
- mem_addr  out  ADDR_WIDTH  instruction memory word address
- mem_read  out  1  memory read request
- mem_rdy  in  1  memory data valid this cycle
- mem_data  in  DATA_WIDTH  memory read data
- ir_out  out  DATA_WIDTH  latched instruction
- ir_valid  out  1  ir_out holds an instruction not yet accepted
- ir_ack  in  1  control unit accepts ir_out
- fetch_fault  out  1  sticky memory-timeout flag
- fetch_count  out  32  number of instructions accepted via handshake

## Operation
- States: IDLE, ADDR, READ, ISSUE, FAULT. All outputs are Moore (decoded from registered state/registers).
- IDLE: if run=1 → ADDR; else stay.
- ADDR: inc_pc=1 for exactly this cycle; mar <= pc_in at the closing edge; wait counter <= 0; → READ unconditionally.
- READ: mem_read=1, mem_addr=mar[ADDR_WIDTH-1:0]. If mem_rdy=1 → ir <= mem_data, → ISSUE. Else wait counter +1; if it reaches TIMEOUT → FAULT.
- ISSUE: ir_valid=1, ir_out stable. On ir_ack=1 → fetch_count +1 (wraps 0xFFFFFFFF→0), then → ADDR if run=1, else IDLE. Without ack, stay (no timeout).
- FAULT: fetch_fault=1, mem_read=0, inc_pc=0, ir_valid=0; stays until clear. run is ignored.
- mem_rdy outside READ and ir_ack outside ISSUE are ignored.
- run deasserted mid-fetch (ADDR/READ/ISSUE): current fetch completes through the handshake, then IDLE; PC is never incremented again.
- inc_pc is asserted exactly once per fetch, always before the memory access. The PC therefore advances by 1 per fetch, including a fetch that later faults.
- mem_addr when not in READ: holds mar (don't-care for memory, but stable).

## Timing
- Reset: on clear high at an edge, the following cycle has state=IDLE, inc_pc=0, mem_read=0, mem_addr=0, ir_out=0, ir_valid=0, fetch_fault=0, fetch_count=0, and wait counter=0.
- Clear in any state, including mid-READ or ISSUE, aborts the fetch. The pending instruction is discarded.
- Zero-wait memory: ADDR cycle N, READ N+1 (mem_rdy=1), ISSUE N+2. With ack in N+2, ADDR at N+3. Minimum fetch period is 3 cycles.
- Each cycle of mem_rdy=0 in READ adds one cycle of latency.
- Timeout: if mem_rdy is low for TIMEOUT consecutive READ cycles, FAULT is entered at the edge ending the TIMEOUT-th cycle. mem_rdy=1 in that cycle wins: the data is captured, with no fault.
- inc_pc and pc_in are sampled at the same edge. mar gets the pre-increment value.

## Test plan
- Reset/idle: assert clear for 2 cycles with run=0 → all outputs 0, state IDLE; hold 5 cycles → inc_pc never asserted.
- Back-to-back fetch: PC model starts at 0x10, memory zero-wait returning 0xA0000000+addr, ack immediately, run=1 for 3 fetches → mem_addr 0x10,0x11,0x12; ir_out 0xA0000010..12; inc_pc pulses every 3 cycles; fetch_count=3.
- Wait states and stalled ack: mem_rdy delayed 4 cycles, ir_ack delayed 3 cycles → ir_valid first seen 6 cycles after ADDR; ir_out stable while unacked; count increments once.
- Timeout: TIMEOUT=16, mem_rdy held 0 → fetch_fault=1 exactly 16 cycles after READ entry, mem_read=0. Repeat with mem_rdy=1 on cycle 16 → no fault, word captured.
- Run drop: deassert run during READ → fetch completes, after ack goes to IDLE; PC advanced by exactly 1.
- Mid-operation clear: clear during ISSUE → next cycle ir_valid=0, ir_out=0, fetch_count=0; re-raise run → fetch restarts with ADDR.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC strobe, instruction-memory read port and IR handshake.
// master = sequencer side, slave = datapath/memory/control side.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  run;
    logic [DATA_WIDTH-1:0] pc_in;
    logic                  inc_pc;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_rdy;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] ir_out;
    logic                  ir_valid;
    logic                  ir_ack;
    logic                  fetch_fault;
    logic [31:0]           fetch_count;

    modport master (
        input  run, pc_in, mem_rdy, mem_data, ir_ack,
        output inc_pc, mem_addr, mem_read, ir_out, ir_valid, fetch_fault, fetch_count
    );

    modport slave (
        output run, pc_in, mem_rdy, mem_data, ir_ack,
        input  inc_pc, mem_addr, mem_read, ir_out, ir_valid, fetch_fault, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: strobes the PC, reads instruction memory, hands the
// word to the control unit over valid/ack, flags memory timeouts, counts accepts.
module fetch_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 16
) (
    input logic               clock,
    input logic               clear,
    fetch_sequencer_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, READ, ISSUE, FAULT} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] ir;
    logic [WW-1:0]         wait_cnt;
    logic [31:0]           count;
    logic                  timed_out;

    // This READ cycle is the TIMEOUT-th consecutive one without mem_rdy.
    assign timed_out = (wait_cnt == WW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.run) state_nx = ADDR;
            ADDR:    state_nx = READ;
            READ: begin
                if (bus.mem_rdy)     state_nx = ISSUE;
                else if (timed_out)  state_nx = FAULT;
            end
            ISSUE:   if (bus.ir_ack) state_nx = bus.run ? ADDR : IDLE;
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            mar      <= '0;
            ir       <= '0;
            wait_cnt <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ADDR: begin
                    // pc_in is the pre-increment value: the PC advances on this same edge.
                    mar      <= bus.pc_in[ADDR_WIDTH-1:0];
                    wait_cnt <= '0;
                end
                READ: begin
                    if (bus.mem_rdy) ir <= bus.mem_data;
                    else             wait_cnt <= wait_cnt + WW'(1);
                end
                ISSUE:   if (bus.ir_ack) count <= count + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.inc_pc      = (state == ADDR);
    assign bus.mem_read    = (state == READ);
    assign bus.mem_addr    = mar;
    assign bus.ir_out      = ir;
    assign bus.ir_valid    = (state == ISSUE);
    assign bus.fetch_fault = (state == FAULT);
    assign bus.fetch_count = count;
endmodule
